// File: rtl/dma_bus_arbiter.sv
// -----------------------------------------------------------------------------
// dma_bus_arbiter
//
// Purpose:
//   Arbitrates the memory bus between the CPU and a DMA engine. A transfer
//   starts with a one-cycle cmd to the DMA engine. It then consists of BURSTS
//   grant episodes. In each episode the engine raises BR and the arbiter
//   answers with BG, once the CPU has no access in flight. The arbiter pulses
//   dma_done after the last episode. It pulses dma_error when the engine fails
//   to request the bus in time, or when it holds the bus too long.
//
// Parameters:
//   BURSTS      grant episodes per transfer (1..15)
//   BR_TIMEOUT  cycles with BR low in WAIT_BR before an error is raised
//   GRANT_MAX   maximum cycles BG may stay high in one episode
//
// Ports:
//   CLK           in   clock, all state changes on the rising edge
//   reset_n       in   asynchronous active-low reset
//   dma_start     in   CPU request to start a transfer (honoured only in IDLE)
//   cpu_bus_busy  in   CPU access in flight; blocks any new grant
//   BR            in   bus request from the DMA engine
//   BG            out  bus grant, registered
//   cmd           out  one-cycle DMA start command, registered
//   cpu_stall     out  CPU must not start new accesses, combinational
//   dma_done      out  one-cycle transfer-complete pulse, registered
//   dma_error     out  one-cycle timeout / overlong-grant pulse, registered
//   grant_count   out  completed grant episodes in the current transfer
//   dbg_state     out  current FSM state encoding, for observation only
//
// Handshake:
//   BR is a level request. BG is raised on the edge that samples BR=1 with
//   cpu_bus_busy=0 in WAIT_BR. BG is held while BR stays high. BG is dropped on
//   the first edge that samples BR=0. An episode completes on that edge.
// -----------------------------------------------------------------------------
module dma_bus_arbiter #(
    parameter int BURSTS     = 3,
    parameter int BR_TIMEOUT = 16,
    parameter int GRANT_MAX  = 8
) (
    input  logic       CLK,
    input  logic       reset_n,
    input  logic       dma_start,
    input  logic       cpu_bus_busy,
    input  logic       BR,
    output logic       BG,
    output logic       cmd,
    output logic       cpu_stall,
    output logic       dma_done,
    output logic       dma_error,
    output logic [3:0] grant_count,
    output logic [2:0] dbg_state
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE   = 3'd1,
        WAIT_BR = 3'd2,
        GRANT   = 3'd3,
        DONE    = 3'd4
    } state_e;

    // One timer serves both WAIT_BR (request timeout) and GRANT (grant length).
    // The two uses are never active at the same time.
    localparam int TMAX = (BR_TIMEOUT > GRANT_MAX) ? BR_TIMEOUT : GRANT_MAX;
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [TW-1:0] BR_LAST    = TW'(BR_TIMEOUT - 1);
    localparam logic [TW-1:0] GRANT_LAST = TW'(GRANT_MAX - 1);
    localparam logic [TW-1:0] TIMER_ONE  = TW'(1);
    localparam logic [3:0]    BURSTS_C   = 4'(BURSTS);

    state_e        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [3:0]    grant_count_q, grant_count_d;
    logic          bg_q, bg_d;
    logic          cmd_q, cmd_d;
    logic          dma_done_q, dma_done_d;
    logic          dma_error_q, dma_error_d;
    logic [3:0]    grant_count_inc;

    assign grant_count_inc = grant_count_q + 4'd1;

    // ------------------------------------------------------------------------
    // Next-state and registered-output logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        timer_d       = timer_q;
        grant_count_d = grant_count_q;
        dma_error_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (dma_start) begin
                    state_d       = ISSUE;
                    grant_count_d = 4'd0;
                end
            end

            ISSUE: begin
                state_d       = WAIT_BR;
                timer_d       = '0;
                grant_count_d = 4'd0;
            end

            WAIT_BR: begin
                if (BR) begin
                    // While the CPU is busy the request waits and the timer
                    // holds. The request is not lost.
                    if (!cpu_bus_busy) begin
                        state_d = GRANT;
                        timer_d = '0;
                    end
                end else if (timer_q == BR_LAST) begin
                    state_d     = IDLE;
                    dma_error_d = 1'b1;
                end else begin
                    timer_d = timer_q + TIMER_ONE;
                end
            end

            GRANT: begin
                // The timer counts completed GRANT cycles. BR low always wins
                // over the length limit, so a release on the last allowed
                // cycle still counts as a normal episode.
                if (!BR) begin
                    timer_d = '0;
                    if (grant_count_q < BURSTS_C) begin
                        grant_count_d = grant_count_inc;
                    end
                    state_d = (grant_count_inc >= BURSTS_C) ? DONE : WAIT_BR;
                end else if (timer_q == GRANT_LAST) begin
                    state_d     = IDLE;
                    dma_error_d = 1'b1;
                end else begin
                    timer_d = timer_q + TIMER_ONE;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // These outputs are decoded from the next state, so each one is high
        // for exactly the cycles spent in its state. They are mutually
        // exclusive with each other and with dma_error, because an error
        // always moves the FSM to IDLE.
        bg_d       = (state_d == GRANT);
        cmd_d      = (state_d == ISSUE);
        dma_done_d = (state_d == DONE);
    end

    // ------------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            timer_q       <= '0;
            grant_count_q <= 4'd0;
            bg_q          <= 1'b0;
            cmd_q         <= 1'b0;
            dma_done_q    <= 1'b0;
            dma_error_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            grant_count_q <= grant_count_d;
            bg_q          <= bg_d;
            cmd_q         <= cmd_d;
            dma_done_q    <= dma_done_d;
            dma_error_q   <= dma_error_d;
        end
    end

    // The CPU is stalled while the DMA owns the bus. It is also stalled as soon
    // as a request is pending in WAIT_BR, so that the CPU's in-flight access
    // can drain and no new access starts.
    assign cpu_stall   = bg_q | ((state_q == WAIT_BR) & BR);

    assign BG          = bg_q;
    assign cmd         = cmd_q;
    assign dma_done    = dma_done_q;
    assign dma_error   = dma_error_q;
    assign grant_count = grant_count_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_dma_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dma_bus_arbiter
//
// Directed bench for dma_bus_arbiter with default parameters (3 bursts,
// BR timeout 16, grant limit 8). Each step drives inputs at the falling edge,
// queues the output vector expected after the next rising edge, and compares
// it at posedge+1. The vector is {BG, cmd, dma_done, dma_error, cpu_stall,
// grant_count}.
// -----------------------------------------------------------------------------
module tb_dma_bus_arbiter;

    localparam int W = 9;

    // ---------------- clock / reset ----------------
    logic       CLK;
    logic       reset_n;
    logic       dma_start;
    logic       cpu_bus_busy;
    logic       BR;
    logic       BG;
    logic       cmd;
    logic       cpu_stall;
    logic       dma_done;
    logic       dma_error;
    logic [3:0] grant_count;
    logic [2:0] dbg_state;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    dma_bus_arbiter #(
        .BURSTS    (3),
        .BR_TIMEOUT(16),
        .GRANT_MAX (8)
    ) dut (
        .CLK         (CLK),
        .reset_n     (reset_n),
        .dma_start   (dma_start),
        .cpu_bus_busy(cpu_bus_busy),
        .BR          (BR),
        .BG          (BG),
        .cmd         (cmd),
        .cpu_stall   (cpu_stall),
        .dma_done    (dma_done),
        .dma_error   (dma_error),
        .grant_count (grant_count),
        .dbg_state   (dbg_state)
    );

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    function automatic logic [W-1:0] v(input logic bg, input logic c, input logic d,
                                       input logic e, input logic s, input logic [3:0] gc);
        return {bg, c, d, e, s, gc};
    endfunction

    task automatic compare(input string tag);
        logic [W-1:0] got;
        logic [W-1:0] exp;
        got = {BG, cmd, dma_done, dma_error, cpu_stall, grant_count};
        exp = exp_q.pop_front();
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed {bg,cmd,done,err,stall,gc}=%b expected=%b (t=%0t)",
                   tag, got, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step(input logic s, input logic b, input logic r,
                        input logic [W-1:0] e, input string tag);
        @(negedge CLK);
        dma_start    = s;
        cpu_bus_busy = b;
        BR           = r;
        exp_q.push_back(e);
        @(posedge CLK);
        #1;
        compare(tag);
    endtask

    // BR is held high for n_hi cycles, then dropped. BG follows one edge later.
    // The release edge bumps grant_count. On the last episode it moves to DONE.
    task automatic episode(input int n_hi, input logic [3:0] gc, input logic last);
        logic [3:0] gn;
        gn = gc + 4'd1;
        for (int i = 0; i < n_hi; i++) begin
            step(1'b0, 1'b0, 1'b1, v(1, 0, 0, 0, 1, gc), "grant_hold");
        end
        if (last) step(1'b0, 1'b0, 1'b0, v(0, 0, 1, 0, 0, gn), "exit_to_done");
        else      step(1'b0, 1'b0, 1'b0, v(0, 0, 0, 0, 0, gn), "exit_to_wait");
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        reset_n      = 1'b0;
        dma_start    = 1'b0;
        cpu_bus_busy = 1'b0;
        BR           = 1'b0;

        // Reset state
        @(posedge CLK);
        #1;
        exp_q.push_back(v(0, 0, 0, 0, 0, 0));
        compare("reset_state");
        #2 reset_n = 1'b1;

        // Nominal: 3 episodes of 4 BR-high cycles
        step(1, 0, 0, v(0, 1, 0, 0, 0, 0), "nominal_cmd");
        step(0, 0, 0, v(0, 0, 0, 0, 0, 0), "nominal_wait");
        episode(4, 4'd0, 1'b0);
        episode(4, 4'd1, 1'b0);
        episode(4, 4'd2, 1'b1);
        step(0, 0, 0, v(0, 0, 0, 0, 0, 3), "idle_holds_count");
        step(0, 0, 1, v(0, 0, 0, 0, 0, 3), "br_in_idle_ignored");

        // Busy hold, same-edge BR+busy, then a stuck BR hits the grant limit
        step(1, 0, 0, v(0, 1, 0, 0, 0, 0), "busy_cmd");
        step(0, 0, 0, v(0, 0, 0, 0, 0, 0), "busy_wait");
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 1, v(0, 0, 0, 0, 1, 0), "busy_hold");
        end
        step(0, 0, 1, v(1, 0, 0, 0, 1, 0), "grant_after_busy");
        for (int i = 0; i < 7; i++) begin
            step(0, 0, 1, v(1, 0, 0, 0, 1, 0), "stuck_bg_high");
        end
        step(0, 0, 1, v(0, 0, 0, 1, 0, 0), "grant_max_error");
        for (int i = 0; i < 8; i++) begin
            step(0, 0, 1, v(0, 0, 0, 0, 0, 0), "stuck_back_idle");
        end

        // BR timeout: error 16 edges after WAIT_BR is entered
        step(1, 0, 0, v(0, 1, 0, 0, 0, 0), "timeout_cmd");
        step(0, 0, 0, v(0, 0, 0, 0, 0, 0), "timeout_enter_wait");
        for (int i = 0; i < 15; i++) begin
            step(0, 0, 0, v(0, 0, 0, 0, 0, 0), "timeout_waiting");
        end
        step(0, 0, 0, v(0, 0, 0, 1, 0, 0), "timeout_error");
        step(0, 0, 0, v(0, 0, 0, 0, 0, 0), "timeout_idle");

        // Asynchronous reset in the middle of the second grant
        step(1, 0, 0, v(0, 1, 0, 0, 0, 0), "rst_cmd");
        step(0, 0, 0, v(0, 0, 0, 0, 0, 0), "rst_wait");
        episode(4, 4'd0, 1'b0);
        step(0, 0, 1, v(1, 0, 0, 0, 1, 1), "rst_second_grant");
        #2 reset_n = 1'b0;
        #1;
        exp_q.push_back(v(0, 0, 0, 0, 0, 0));
        compare("async_reset_between_edges");
        @(posedge CLK);
        #1;
        exp_q.push_back(v(0, 0, 0, 0, 0, 0));
        compare("reset_held_no_done");
        #2 reset_n = 1'b1;
        BR = 1'b0;
        step(1, 0, 0, v(0, 1, 0, 0, 0, 0), "start_after_reset");

        // Starts during ISSUE, WAIT_BR and DONE are ignored
        step(1, 0, 0, v(0, 0, 0, 0, 0, 0), "start_in_issue");
        for (int k = 0; k < 3; k++) begin
            step(1, 0, 0, v(0, 0, 0, 0, 0, 4'(k)), "start_in_wait");
            episode(2, 4'(k), k == 2);
        end
        step(1, 0, 1, v(0, 0, 0, 0, 0, 3), "start_in_done");
        step(0, 0, 0, v(0, 0, 0, 0, 0, 3), "no_second_cmd");
        step(0, 0, 0, v(0, 0, 0, 0, 0, 3), "still_idle");

        // ---------------- final report ----------------
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
